// File: rtl/fir_pkg.sv
// Types and constants shared by the FIR stage and its AXI-Stream decimator.
package fir_pkg;

  localparam int unsigned FIR_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dec_state_e;

  // FIFO entry layout, {tdata, tlast}, at the default FIR sample width
  typedef struct packed {
    logic signed [FIR_DATA_WIDTH-1:0] tdata;
    logic                             tlast;
  } fir_entry_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module fir_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fir_axis_decimator.sv
// Keeps every DECIM-th FIR sample (plus packet-closing beats) and buffers them
// for a backpressuring sink; beats offered while full are counted as lost.
module fir_axis_decimator
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = FIR_DATA_WIDTH,
  parameter int unsigned DECIM          = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     s_axis_dec_tdata,
  input  logic                      s_axis_dec_tvalid,
  input  logic                      s_axis_dec_tlast,
  output logic                      s_axis_dec_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_dec_tdata,
  output logic                      m_axis_dec_tvalid,
  output logic                      m_axis_dec_tlast,
  input  logic                      m_axis_dec_tready,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned EW = DATA_WIDTH + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  dec_state_e                state_q, state_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          lost;
  logic          keep;
  logic          push;
  logic          pop;
  logic [EW-1:0] rd_word;
  logic [CW-1:0] unused_count;

  assign s_axis_dec_tready = reset && !fifo_full;
  assign accept = s_axis_dec_tvalid && s_axis_dec_tready;
  assign lost   = s_axis_dec_tvalid && !s_axis_dec_tready;
  // A beat opening a packet, landing on phase 0, or closing a packet is kept
  assign keep   = (state_q == IDLE) || (phase_q == '0) || s_axis_dec_tlast;
  assign push   = accept && keep;
  assign pop    = m_axis_dec_tvalid && m_axis_dec_tready;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (accept) begin
      if (s_axis_dec_tlast) begin
        state_d = IDLE;
        phase_d = '0;
      end else begin
        state_d = RUN;
        phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
      end
    end
    if (lost) begin
      if (drop_q != '1) drop_d = drop_q + DROP_CNT_WIDTH'(1);
      if (keep)         overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({s_axis_dec_tdata, s_axis_dec_tlast}),
    .pop_i   (pop),
    .rdata_o (rd_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_count)
  );

  assign m_axis_dec_tvalid = !fifo_empty;
  assign m_axis_dec_tdata  = rd_word[EW-1:1];
  assign m_axis_dec_tlast  = rd_word[0];
  assign overflow          = overflow_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_fir_axis_decimator.sv
// Scoreboard bench: a DECIM=4 and a DECIM=1 decimator driven side by side.
module tb_fir_axis_decimator;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][DW-1:0] s_tdata, m_tdata;
  logic [1:0]         s_tvalid, s_tlast, s_tready;
  logic [1:0]         m_tvalid, m_tlast, m_tready, ovf;
  logic [1:0][7:0]    dcnt;

  fir_axis_decimator #(.DATA_WIDTH(DW), .DECIM(4), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(8)) u_dec4 (
    .clk(clk), .reset(reset),
    .s_axis_dec_tdata(s_tdata[0]), .s_axis_dec_tvalid(s_tvalid[0]),
    .s_axis_dec_tlast(s_tlast[0]), .s_axis_dec_tready(s_tready[0]),
    .m_axis_dec_tdata(m_tdata[0]), .m_axis_dec_tvalid(m_tvalid[0]),
    .m_axis_dec_tlast(m_tlast[0]), .m_axis_dec_tready(m_tready[0]),
    .overflow(ovf[0]), .drop_count(dcnt[0]));

  fir_axis_decimator #(.DATA_WIDTH(DW), .DECIM(1), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(8)) u_dec1 (
    .clk(clk), .reset(reset),
    .s_axis_dec_tdata(s_tdata[1]), .s_axis_dec_tvalid(s_tvalid[1]),
    .s_axis_dec_tlast(s_tlast[1]), .s_axis_dec_tready(s_tready[1]),
    .m_axis_dec_tdata(m_tdata[1]), .m_axis_dec_tvalid(m_tvalid[1]),
    .m_axis_dec_tlast(m_tlast[1]), .m_axis_dec_tready(m_tready[1]),
    .overflow(ovf[1]), .drop_count(dcnt[1]));

  int checks = 0;
  int failures = 0;

  // Reference model state per DUT
  int  dec_f [2];
  int  occ   [2];
  int  phase [2];
  int  drops [2];
  bit  ovfm  [2];
  logic [DW:0] q0 [$];
  logic [DW:0] q1 [$];

  // Stimulus for the upcoming clock edge
  bit   [1:0]         v, l, sr;
  logic [1:0][DW-1:0] d;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=0x%0h required=0x%0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [DW:0] e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop_exp(input int i, output bit ok, output logic [DW:0] e);
    ok = 1'b0;
    e  = '0;
    if (i == 0 && q0.size() > 0) begin ok = 1'b1; e = q0.pop_front(); end
    if (i == 1 && q1.size() > 0) begin ok = 1'b1; e = q1.pop_front(); end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      occ[i] = 0; phase[i] = 0; drops[i] = 0; ovfm[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // What happens at the next edge, from the stated rules
  task automatic model_step(input int i);
    bit full, popb, acc, kept;
    full = (occ[i] >= DEPTH);
    popb = (occ[i] > 0) && sr[i];
    acc  = v[i] && !full;
    kept = (phase[i] == 0) || l[i];
    if (v[i] && full) begin
      if (drops[i] < 255) drops[i]++;
      if (kept) ovfm[i] = 1'b1;
    end
    if (acc) begin
      if (kept) push_exp(i, {d[i], l[i]});
      phase[i] = (l[i] || phase[i] == dec_f[i] - 1) ? 0 : phase[i] + 1;
    end
    occ[i] = occ[i] + ((acc && kept) ? 1 : 0) - (popb ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = sr;
    for (int i = 0; i < 2; i++) begin
      chk("s_tready", i, 32'(s_tready[i]), 32'(reset && (occ[i] < DEPTH)));
      chk("m_tvalid", i, 32'(m_tvalid[i]), 32'(occ[i] > 0));
      if (occ[i] == 0) chk("m_tdata_empty", i, 32'(m_tdata[i]), 32'd0);
      chk("drop_count", i, 32'(dcnt[i]), 32'(drops[i]));
      chk("overflow", i, 32'(ovf[i]), 32'(ovfm[i]));
      if (reset) model_step(i);
    end
  endtask

  task automatic feed(input int i, input int first, input int last_val, input bit last_on_end);
    for (int k = first; k <= last_val; k++) begin
      v[i] = 1'b1;
      d[i] = DW'(k);
      l[i] = last_on_end && (k == last_val);
      cycle();
    end
    v[i] = 1'b0;
    l[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    v = '0; l = '0; sr = '1;
    while ((q0.size() > 0 || q1.size() > 0 || occ[0] > 0 || occ[1] > 0) && n < 60) begin
      cycle();
      n++;
    end
    chk("drain_leftover", 0, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Monitor: compare each handshake against the scoreboard and check stall stability
  bit   [1:0]       stall_q;
  logic [1:0][DW:0] held;
  always @(negedge clk) begin
    bit ok;
    logic [DW:0] e;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        stall_q[i] = 1'b0;
      end else begin
        if (stall_q[i])
          chk("stall_hold", i, 32'({m_tvalid[i], m_tdata[i], m_tlast[i]}), 32'({1'b1, held[i]}));
        if (m_tvalid[i] && m_tready[i]) begin
          pop_exp(i, ok, e);
          if (!ok) begin
            checks++;
            failures++;
            $display("FAIL spurious_output dut%0d actual=0x%0h required=none", i, {m_tdata[i], m_tlast[i]});
          end else begin
            chk("out_word", i, 32'({m_tdata[i], m_tlast[i]}), 32'(e));
          end
        end
        stall_q[i] = m_tvalid[i] && !m_tready[i];
        held[i]    = {m_tdata[i], m_tlast[i]};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_f[0] = 4;
    dec_f[1] = 1;
    v = '0; l = '0; sr = '1; d = '0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = '1;
    stall_q = '0; held = '0;
    model_reset();
    repeat (2) cycle();
    @(negedge clk) reset = 1'b1;
    cycle();

    // 1..12 continuous, last on 12 -> 1,5,9,12
    feed(0, 1, 12, 1'b1);
    drain();
    // two packets: 1..6 and 7..10 -> 1,5,6,7,10
    feed(0, 1, 6, 1'b1);
    feed(0, 7, 10, 1'b1);
    drain();
    // single-beat packet of -3 while idle
    v[0] = 1'b1; d[0] = 16'hFFFD; l[0] = 1'b1;
    cycle();
    drain();

    // DECIM=1 with a stalled sink: 1..4 stored, 5 and 6 lost
    sr[1] = 1'b0;
    feed(1, 1, 6, 1'b0);
    repeat (2) cycle();
    chk("stall_drops", 1, 32'(dcnt[1]), 32'd2);
    chk("stall_overflow", 1, 32'(ovf[1]), 32'd1);
    chk("stall_full_tready", 1, 32'(s_tready[1]), 32'd0);
    drain();

    // DECIM=4 sink stalled on the first output while input continues
    for (int k = 1; k <= 12; k++) begin
      sr[0] = (k > 4);
      v[0] = 1'b1; d[0] = DW'(k); l[0] = (k == 12);
      cycle();
    end
    drain();
    chk("no_drop_overflow", 0, 32'(ovf[0]), 32'd0);
    chk("no_drop_count", 0, 32'(dcnt[0]), 32'd0);

    // Async reset mid-packet with two entries buffered
    sr[0] = 1'b0;
    feed(0, 1, 5, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_m_tvalid", i, 32'(m_tvalid[i]), 32'd0);
      chk("rst_m_tdata", i, 32'(m_tdata[i]), 32'd0);
      chk("rst_m_tlast", i, 32'(m_tlast[i]), 32'd0);
      chk("rst_s_tready", i, 32'(s_tready[i]), 32'd0);
      chk("rst_overflow", i, 32'(ovf[i]), 32'd0);
      chk("rst_drop_count", i, 32'(dcnt[i]), 32'd0);
    end
    model_reset();
    v = '0; l = '0; sr = '1;
    cycle();
    @(negedge clk) reset = 1'b1;
    feed(0, 20, 23, 1'b0);
    drain();

    // Randomised traffic on both decimators
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        v[i]  = ($urandom_range(0, 3) != 0);
        d[i]  = DW'($urandom);
        l[i]  = ($urandom_range(0, 7) == 0);
        sr[i] = ($urandom_range(0, 9) < 6);
      end
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
